// File: rtl/rng_seq_pkg.sv
// ============================================================================
// Module   : rng_seq_pkg
// Brief    : Shared state encoding, constants and interval helper for the
//            dice-roll sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rng_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLL    = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int ROLL_CNT_W = 8;

  function automatic int unsigned interval_len(input int unsigned base, input int unsigned k);
    return base << k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rng_interval_timer.sv
// ============================================================================
// Module   : rng_interval_timer
// Brief    : Step-interval counter; interval k lasts BASE_INTERVAL<<k cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_interval_timer
  import rng_seq_pkg::*;
#(
  parameter int unsigned BASE_INTERVAL = 2,
  parameter int unsigned NUM_STEPS     = 3,
  parameter int unsigned CNT_W         = $clog2(BASE_INTERVAL << NUM_STEPS) + 1,
  parameter int unsigned K_W           = $clog2(NUM_STEPS) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire,
  output logic o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] w_lim;

  assign w_lim    = CNT_W'(interval_len(BASE_INTERVAL, 32'(r_k)) - 32'd1);
  assign o_expire = (r_cnt == w_lim);
  assign o_last   = (r_k == K_W'(NUM_STEPS - 1));

  // k holds at the last index; the sequencer leaves ROLL on that expiry
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_k   <= '0;
    end else if (i_run) begin
      if (o_expire) begin
        r_cnt <= '0;
        if (!o_last) r_k <= r_k + K_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rng_roll_sequencer.sv
// ============================================================================
// Module   : rng_roll_sequencer
// Brief    : Dice-roll sequencer: slowing LFSR step pulses, settle, capture.
//            Define RNG_ROLL_STATS_EN to add the saturating o_roll_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_roll_sequencer
  import rng_seq_pkg::*;
#(
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned BASE_INTERVAL = 2,
  parameter int unsigned NUM_STEPS     = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_rand,
  output logic              o_step,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_prev_result
`ifdef RNG_ROLL_STATS_EN
  ,
  output logic [ROLL_CNT_W-1:0] o_roll_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_clr;
  logic   w_run;
  logic   w_step;
  logic   w_cap;
  logic   w_expire;
  logic   w_last;

  rng_interval_timer #(
    .BASE_INTERVAL (BASE_INTERVAL),
    .NUM_STEPS     (NUM_STEPS)
  ) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .i_clr    (w_clr),
    .i_run    (w_run),
    .o_expire (w_expire),
    .o_last   (w_last)
  );

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_run  = 1'b0;
    w_step = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next = ROLL;
          w_clr  = 1'b1;
        end
      end
      ROLL: begin
        // restart outranks stop, stop outranks a due step
        if (i_start) begin
          w_clr = 1'b1;
        end else if (i_stop) begin
          w_next = SETTLE;
        end else begin
          w_run = 1'b1;
          if (w_expire) begin
            w_step = 1'b1;
            if (w_last) w_next = SETTLE;
          end
        end
      end
      SETTLE:  w_next = CAPTURE;
      CAPTURE: begin
        w_cap  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      o_step        <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result      <= '0;
      o_prev_result <= '0;
    end else begin
      r_state <= w_next;
      o_step  <= w_step;
      o_busy  <= (w_next != IDLE);
      o_done  <= w_cap;
      if (w_cap) begin
        o_prev_result <= o_result;
        o_result      <= i_rand;
      end
    end
  end

`ifdef RNG_ROLL_STATS_EN
  logic [ROLL_CNT_W-1:0] r_roll_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_roll_cnt <= '0;
    end else if (w_cap && (r_roll_cnt != {ROLL_CNT_W{1'b1}})) begin
      r_roll_cnt <= r_roll_cnt + ROLL_CNT_W'(1);
    end
  end

  assign o_roll_cnt = r_roll_cnt;
`endif

endmodule

`default_nettype wire
